// File: rtl/bus_xfer_ctrl.sv
// Burst engine behind the bus arbiter: runs the granted master's burst on the
// shared slave port, steers per-master data, and flags multi-hot grants.
module bus_xfer_ctrl #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          bus_grant,
  output logic                          bus_ack,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*LEN_W-1:0]    m_len,
  input  logic [N_MASTERS-1:0]          m_write,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_beat,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic                          grant_err
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic              write_q;
  logic              grant_err_q;

  logic [IDX_W:0]    grant_cnt;
  logic [IDX_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] grant_addr;
  logic [LEN_W-1:0]  grant_len;
  logic              grant_write;
  logic [DATA_W-1:0] sel_wdata;
  logic              grant_one;
  logic              grant_multi;
  logic              beat;

  // Decode the raw grant (population count plus the granted master's fields)
  // and the data mux for the master that owns the current burst.
  always_comb begin
    grant_cnt   = '0;
    grant_idx   = '0;
    grant_addr  = '0;
    grant_len   = '0;
    grant_write = 1'b0;
    sel_wdata   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      grant_cnt = grant_cnt + (IDX_W+1)'(bus_grant[i]);
      if (bus_grant[i]) begin
        grant_idx   = IDX_W'(i);
        grant_addr  = m_addr[i*ADDR_W +: ADDR_W];
        grant_len   = m_len[i*LEN_W +: LEN_W];
        grant_write = m_write[i];
      end
      if (idx_q == IDX_W'(i)) begin
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_one   = (grant_cnt == (IDX_W+1)'(1));
  assign grant_multi = (grant_cnt >  (IDX_W+1)'(1));
  assign beat        = (state == XFER) && s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_one) begin
          state_next = XFER;
        end else if (grant_multi) begin
          state_next = ACK;
        end
      end
      XFER: begin
        if (beat && (count_q == len_q)) begin
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst context is captured once in IDLE; grant changes afterwards are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      write_q     <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (grant_one) begin
          idx_q   <= grant_idx;
          addr_q  <= grant_addr;
          len_q   <= grant_len;
          write_q <= grant_write;
          count_q <= '0;
        end else if (grant_multi) begin
          grant_err_q <= 1'b1;
        end
      end
      if (beat) begin
        addr_q  <= addr_q + ADDR_W'(1);
        count_q <= count_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    s_req   = 1'b0;
    s_we    = 1'b0;
    bus_ack = 1'b0;
    s_wdata = '0;
    m_beat  = '0;
    case (state)
      XFER: begin
        s_req   = 1'b1;
        s_we    = write_q;
        s_wdata = sel_wdata;
        for (int i = 0; i < N_MASTERS; i++) begin
          m_beat[i] = s_ready && (idx_q == IDX_W'(i));
        end
      end
      ACK:     bus_ack = 1'b1;
      default: ;
    endcase
  end

  assign s_addr    = addr_q;
  assign m_rdata   = s_rdata;
  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a vector table of bursts, hand-written corner
// sequences, and random bursts checked against a beat-by-beat burst model.
module tb_bus_xfer_ctrl;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int BUDGET = 600;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      bus_grant;
  logic              bus_ack;
  logic [N*AW-1:0]   m_addr;
  logic [N*LW-1:0]   m_len;
  logic [N-1:0]      m_write;
  logic [N*DW-1:0]   m_wdata;
  logic [N-1:0]      m_beat;
  logic [DW-1:0]     m_rdata;
  logic              s_req;
  logic              s_we;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic              s_ready;
  logic [DW-1:0]     s_rdata;
  logic              grant_err;

  int   compared   = 0;
  int   mismatched = 0;
  logic model_err  = 1'b0;

  typedef struct {
    logic [N-1:0]  grant;
    int            idx;
    logic [AW-1:0] addr;
    int            len;
    logic          wr;
    logic [31:0]   mask;
    logic [DW-1:0] wd;
    int            exp_ack;
    logic          exp_err;
  } vec_t;

  vec_t vecs[8];

  bus_xfer_ctrl #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_grant (bus_grant),
    .bus_ack   (bus_ack),
    .m_addr    (m_addr),
    .m_len     (m_len),
    .m_write   (m_write),
    .m_wdata   (m_wdata),
    .m_beat    (m_beat),
    .m_rdata   (m_rdata),
    .s_req     (s_req),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .grant_err (grant_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [AW-1:0] addr, input int len,
                               input logic wr, input logic [DW-1:0] wd);
    m_addr[idx*AW +: AW]  = addr;
    m_len[idx*LW +: LW]   = LW'(len);
    m_write[idx]          = wr;
    m_wdata[idx*DW +: DW] = wd;
  endtask

  // Cycles from the grant cycle to the ack cycle: one XFER cycle per mask bit
  // consumed until len+1 ready cycles have been seen, plus the ACK cycle.
  function automatic int model_ack(input int len, input logic [31:0] mask);
    int seen = 0;
    int c    = 0;
    while (seen <= len) begin
      if (mask[c % 32]) seen++;
      c++;
    end
    return c + 1;
  endfunction

  task automatic run_burst(input logic [N-1:0] grant, input int idx, input logic [AW-1:0] addr,
                           input int len, input logic wr, input logic [31:0] mask,
                           input logic [DW-1:0] wd_first, output int ack_cycle);
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic [AW-1:0] ea;
    logic          rdy;
    bit            pending;
    int            beats;
    wd = wd_first;
    pending = 0;
    beats = 0;
    ack_cycle = -1;
    next_cycle();
    applyStimulus(idx, addr, len, wr, wd);
    bus_grant = grant;
    s_ready = 1'($urandom);
    #1;
    checkOutput("grant_cycle_sreq", s_req, 0);
    checkOutput("grant_cycle_beat", m_beat, 0);
    for (int c = 1; c <= BUDGET && ack_cycle < 0; c++) begin
      next_cycle();
      if (pending) begin
        wd = $urandom;
        m_wdata[idx*DW +: DW] = wd;
        pending = 0;
      end
      if (beats <= len) begin
        rdy = mask[(c-1) % 32];
        rd = $urandom;
        s_ready = rdy;
        s_rdata = rd;
        #1;
        ea = addr + AW'(beats);
        checkOutput("xfer_sreq", s_req, 1);
        checkOutput("xfer_swe", s_we, wr);
        checkOutput("xfer_saddr", s_addr, ea);
        checkOutput("xfer_swdata", s_wdata, wd);
        checkOutput("xfer_mbeat", m_beat, rdy ? grant : '0);
        checkOutput("xfer_ack", bus_ack, 0);
        if (rdy) begin
          checkOutput("xfer_mrdata", m_rdata, rd);
          beats++;
          pending = 1;
        end
      end else begin
        s_ready = 1'($urandom);
        #1;
        checkOutput("ack_pulse", bus_ack, 1);
        checkOutput("ack_sreq", s_req, 0);
        checkOutput("ack_mbeat", m_beat, 0);
        checkOutput("ack_granterr", grant_err, model_err);
        ack_cycle = c;
      end
    end
    if (ack_cycle < 0) checkOutput("ack_timeout", 0, 1);
    next_cycle();
    bus_grant = '0;
    #1;
    checkOutput("post_ack_idle", {bus_ack, s_req}, 0);
  endtask

  task automatic run_multi(input logic [N-1:0] grant, output int ack_cycle);
    next_cycle();
    bus_grant = grant;
    s_ready = 1'b1;
    #1;
    checkOutput("multi_t0_sreq", s_req, 0);
    next_cycle();
    model_err = 1'b1;
    checkOutput("multi_granterr", grant_err, 1);
    checkOutput("multi_ack", bus_ack, 1);
    checkOutput("multi_sreq", s_req, 0);
    ack_cycle = bus_ack ? 1 : -1;
    next_cycle();
    bus_grant = '0;
    #1;
    checkOutput("multi_after_ack", {bus_ack, s_req}, 0);
    checkOutput("multi_sticky", grant_err, 1);
  endtask

  initial begin
    int ack;
    logic [N-1:0] g;
    int idx, len;
    logic [31:0] mask;
    logic [N-1:0] multi_opts [4];

    vecs[0] = '{3'b001, 0, 16'h0010, 0,  1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 2,  1'b0};
    vecs[1] = '{3'b010, 1, 16'h0100, 3,  1'b0, 32'hAAAA_AAAA, 32'h0000_1111, 9,  1'b0};
    vecs[2] = '{3'b100, 2, 16'hFFFE, 3,  1'b1, 32'hFFFF_FFFF, 32'h2222_2222, 5,  1'b0};
    vecs[3] = '{3'b010, 1, 16'h1234, 15, 1'b1, 32'hFFFF_FFFF, 32'h3333_3333, 17, 1'b0};
    vecs[4] = '{3'b001, 0, 16'hFFFF, 1,  1'b0, 32'hFFFF_FFFC, 32'h4444_4444, 5,  1'b0};
    vecs[5] = '{3'b011, 0, 16'h0000, 0,  1'b0, 32'hFFFF_FFFF, 32'h0,         1,  1'b1};
    vecs[6] = '{3'b100, 2, 16'h0040, 2,  1'b0, 32'hFFFF_FFFF, 32'h5555_5555, 4,  1'b0};
    vecs[7] = '{3'b111, 0, 16'h0000, 0,  1'b0, 32'hFFFF_FFFF, 32'h0,         1,  1'b1};
    multi_opts = '{3'b011, 3'b101, 3'b110, 3'b111};

    reset = 1'b1;
    bus_grant = '0;
    m_addr = '0;
    m_len = '0;
    m_write = '0;
    m_wdata = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    next_cycle();
    next_cycle();
    checkOutput("rst_sreq", s_req, 0);
    checkOutput("rst_ack", bus_ack, 0);
    checkOutput("rst_granterr", grant_err, 0);
    checkOutput("rst_saddr", s_addr, 0);
    checkOutput("rst_swe", s_we, 0);
    checkOutput("rst_swdata", s_wdata, 0);
    checkOutput("rst_mbeat", m_beat, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      s_ready = 1'($urandom);
      #1;
      checkOutput("idle_outputs", {s_req, bus_ack, m_beat, grant_err}, 0);
    end

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].exp_err) begin
        run_multi(vecs[v].grant, ack);
      end else begin
        run_burst(vecs[v].grant, vecs[v].idx, vecs[v].addr, vecs[v].len, vecs[v].wr,
                  vecs[v].mask, vecs[v].wd, ack);
      end
      checkOutput($sformatf("vec%0d_ack_latency", v), ack, vecs[v].exp_ack);
    end

    // Back-to-back bursts from one master: ACK to next XFER is two cycles.
    next_cycle();
    applyStimulus(0, 16'h0500, 0, 1'b1, 32'hDEAD_BEEF);
    bus_grant = 3'b001;
    s_ready = 1'b1;
    next_cycle();
    checkOutput("b2b_first_sreq", s_req, 1);
    next_cycle();
    checkOutput("b2b_first_ack", bus_ack, 1);
    next_cycle();
    checkOutput("b2b_gap_idle", {s_req, bus_ack}, 0);
    next_cycle();
    checkOutput("b2b_second_sreq", s_req, 1);
    checkOutput("b2b_second_saddr", s_addr, 16'h0500);
    next_cycle();
    checkOutput("b2b_second_ack", bus_ack, 1);
    next_cycle();
    bus_grant = '0;
    #1;
    checkOutput("b2b_idle", {s_req, bus_ack}, 0);

    // Reset during the second beat of a four-beat burst.
    next_cycle();
    applyStimulus(2, 16'h0200, 3, 1'b1, 32'h0BAD_F00D);
    bus_grant = 3'b100;
    s_ready = 1'b1;
    next_cycle();
    checkOutput("rstmid_beat1_saddr", s_addr, 16'h0200);
    next_cycle();
    checkOutput("rstmid_beat2_saddr", s_addr, 16'h0201);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus_grant = '0;
    model_err = 1'b0;
    #1;
    checkOutput("rstmid_sreq", s_req, 0);
    checkOutput("rstmid_ack", bus_ack, 0);
    checkOutput("rstmid_granterr", grant_err, 0);
    checkOutput("rstmid_mbeat", m_beat, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checkOutput("rstmid_no_ack", {bus_ack, s_req}, 0);
    end
    run_burst(3'b001, 0, 16'h0000, 1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, ack);
    checkOutput("rstmid_recover_latency", ack, 3);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        run_multi(multi_opts[$urandom_range(0, 3)], ack);
        checkOutput("rand_multi_latency", ack, 1);
      end else begin
        idx  = $urandom_range(0, N-1);
        g    = N'(1) << idx;
        len  = $urandom_range(0, 15);
        mask = $urandom | $urandom | 32'h1;
        run_burst(g, idx, AW'($urandom), len, 1'($urandom), mask, $urandom, ack);
        checkOutput("rand_ack_latency", ack, model_ack(len, mask));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

- Downstream companion of `busarbiter`: consumes its one-hot `bus_grant` and runs the granted master's burst on a single shared slave port.
- Pulses `bus_ack` when the burst completes, so the arbiter can re-arbitrate.
- Owns the beat counter, address sequencing, per-master data steering and grant-sanity checking for the shared bus.

## Interface
Parameters:
- `N_MASTERS`, 3, number of masters; matches the arbiter vector width.
- `ADDR_W`, 16, slave address width.
- `DATA_W`, 32, data width.
- `LEN_W`, 4, burst length field width; field value = beats-1.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bus_grant`  in  N_MASTERS  one-hot grant from the arbiter.
- `bus_ack`  out  1  one-cycle transfer-complete pulse to the arbiter.
- `m_addr`  in  N_MASTERS*ADDR_W  per-master start address; master i in slice i.
- `m_len`  in  N_MASTERS*LEN_W  per-master burst length minus one.
- `m_write`  in  N_MASTERS  per-master direction; 1 = write.
- `m_wdata`  in  N_MASTERS*DATA_W  per-master write data for the current beat.
- `m_beat`  out  N_MASTERS  per-master beat-done strobe.
- `m_rdata`  out  DATA_W  read data, valid with `m_beat`.
- `s_req`  out  1  slave request.
- `s_we`  out  1  slave write enable.
- `s_addr`  out  ADDR_W  slave address.
- `s_wdata`  out  DATA_W  slave write data.
- `s_ready`  in  1  slave accepts or returns a beat.
- `s_rdata`  in  DATA_W  slave read data.
- `grant_err`  out  1  sticky flag for a multi-hot grant.

## Operation
FSM states: IDLE, XFER, ACK.

IDLE:
- If `bus_grant` is exactly one-hot: latch master index, `m_addr`, `m_len`, `m_write` of that index; clear beat count; go to XFER.
- If `bus_grant` has more than one bit set: set `grant_err`, go to ACK with no slave traffic.
- If `bus_grant` is zero: stay in IDLE.

XFER:
- `s_req`=1.
- `s_we` = latched write flag.
- `s_addr` = latched address register.
- `s_wdata` = `m_wdata` slice of the latched index (combinational mux).
- A beat completes in a cycle with `s_req`&`s_ready`. That cycle:
  - `m_beat[idx]`=1 (combinational) and `m_rdata`=`s_rdata` (pass-through).
  - Address register increments by 1, mod 2^ADDR_W, so 0xFFFF wraps to 0x0000.
  - Beat count increments.
- The beat that completes with count == latched len moves the FSM to ACK.
- `s_ready` is ignored outside XFER.

ACK:
- `bus_ack`=1 for exactly one cycle, then IDLE.

General rules:
- Grant changes during XFER/ACK are ignored; the latched index governs the whole burst.
- The master updates `m_wdata` after each `m_beat` pulse.
- `grant_err` clears only on `reset`.

## Timing
- Reset: at the `clk` edge with `reset`=1, the FSM goes to IDLE and every registered output goes to 0 (`bus_ack`, `s_req`, `s_we`, `s_addr`, `grant_err`, beat count). Combinational outputs (`m_beat`, `s_wdata`) follow to 0 from the IDLE state.
- Reset mid-burst: `s_req` drops at that edge, no `bus_ack` is issued, and remaining beats are abandoned.
- Latency with grant first seen in IDLE at cycle T:
  - `s_req` high from T+1.
  - With `s_ready` always 1, a burst of len L has handshakes at T+1..T+1+L.
  - `bus_ack` is at T+2+L.
  - The FSM is back in IDLE at T+3+L.
- Wait states: each cycle with `s_ready`=0 in XFER holds all slave outputs stable and adds one cycle.
- The arbiter samples `bus_ack` and updates `bus_grant` at the end of the ACK cycle. IDLE therefore sees the new grant, or NO_GRANT, the next cycle.
- Back-to-back bursts from the same master lose one IDLE cycle, so the gap is ACK to XFER = 2 cycles.
- Multi-hot grant: `grant_err`=1 and `bus_ack`=1 both at T+1; `s_req` never rises.

## Test plan
- Reset then idle: `bus_grant`=000 for 5 cycles -> `s_req`, `bus_ack`, `m_beat`, `grant_err` all 0.
- Single write: grant=001, m_addr0=0x0010, len0=0, write0=1, wdata0=0xA5A5A5A5, `s_ready`=1 -> at T+1: `s_req`=1, `s_addr`=0x0010, `s_wdata`=0xA5A5A5A5, `m_beat`=001; at T+2: `bus_ack`=1.
- 4-beat read with waits: grant=010, addr1=0x0100, len1=3, `s_ready` low every other cycle -> `s_addr` 0x0100..0x0103, four `m_beat`=010 pulses with `m_rdata`=`s_rdata`, then one `bus_ack`.
- Address wrap: grant=100, addr2=0xFFFE, len2=3 -> `s_addr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Multi-hot grant=011 -> `grant_err`=1 (sticky), `bus_ack` pulse at T+1, no `s_req`.
- Reset during beat 2 of a len=3 burst -> `s_req`=0 next edge, no `bus_ack`; a new grant is then served normally from address 0.
